// File: rtl/synth_pkg.sv
// Shared widths, FSM state type and reference period for the oscillator phase path.
package synth_pkg;

  localparam int PERIOD_W = 16;
  localparam int FRAC_W   = 8;

  typedef enum logic [0:0] {IDLE, MULT} mul_state_t;

  localparam logic [PERIOD_W-1:0] A4_PERIOD = 16'd22727;

endpackage

// File: rtl/sequential_multiplier.sv
// Phase-to-count converter: count_out = floor(q_in * divider / 2^FRAC_W),
// computed shift-and-add, one multiplier bit per clock.
module sequential_multiplier
  import synth_pkg::*;
(
  input  logic                clk,
  input  logic                nrst,
  input  logic                start,
  input  logic [PERIOD_W-1:0] divider,
  input  logic [FRAC_W-1:0]   q_in,
  output logic [PERIOD_W-1:0] count_out,
  output logic                busy,
  output logic                done
);

  localparam int ACC_W = PERIOD_W + FRAC_W;
  localparam int SEL_W = $clog2(FRAC_W);
  localparam int IDX_W = SEL_W + 1;

  mul_state_t          state_q;
  logic [PERIOD_W-1:0] divider_q;
  logic [FRAC_W-1:0]   q_q;
  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_d;
  logic [ACC_W-1:0]    addend_d;
  logic [IDX_W-1:0]    bit_idx_q;
  logic [SEL_W-1:0]    sel_d;

  // 24-bit accumulator holds 255 * 65535 without overflow; the result is the top PERIOD_W bits.
  always_comb begin
    sel_d    = bit_idx_q[SEL_W-1:0];
    addend_d = '0;
    if (q_q[sel_d]) begin
      addend_d = {{FRAC_W{1'b0}}, divider_q} << sel_d;
    end
    acc_d = acc_q + addend_d;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      divider_q <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      bit_idx_q <= '0;
      count_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            divider_q <= divider;
            q_q       <= q_in;
            acc_q     <= '0;
            bit_idx_q <= '0;
            busy      <= 1'b1;
            state_q   <= MULT;
          end
        end
        MULT: begin
          acc_q     <= acc_d;
          bit_idx_q <= bit_idx_q + IDX_W'(1);
          if (bit_idx_q == IDX_W'(FRAC_W - 1)) begin
            count_out <= acc_d[ACC_W-1:FRAC_W];
            done      <= 1'b1;
            busy      <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_multiplier.sv
// Directed bench for sequential_multiplier: latency, values, busy-start, back-to-back, reset abort.
module tb_sequential_multiplier;
  import synth_pkg::*;

  logic                clk;
  logic                nrst;
  logic                start;
  logic [PERIOD_W-1:0] divider;
  logic [FRAC_W-1:0]   q_in;
  logic [PERIOD_W-1:0] count_out;
  logic                busy;
  logic                done;

  int n_pass = 0;
  int n_chk  = 0;

  sequential_multiplier dut (
    .clk       (clk),
    .nrst      (nrst),
    .start     (start),
    .divider   (divider),
    .q_in      (q_in),
    .count_out (count_out),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Present operands with start for one edge, then scramble the inputs.
  task automatic issue(input logic [PERIOD_W-1:0] d, input logic [FRAC_W-1:0] q);
    divider = d;
    q_in    = q;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    divider = PERIOD_W'($urandom);
    q_in    = FRAC_W'($urandom);
  endtask

  // Count negedges until done is seen (bounded); leaves the bench in the done cycle.
  task automatic wait_done(output int n, output logic busy_first);
    n = 0;
    busy_first = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      n++;
      if (k == 0) busy_first = busy;
      if (done) break;
    end
    if (!done) n = 99;
  endtask

  int   n;
  int   pulses;
  logic b0;

  initial begin
    nrst    = 1'b1;
    start   = 1'b0;
    divider = '0;
    q_in    = '0;
    #1 nrst = 1'b0;

    // Reset held for two clocks.
    @(negedge clk);
    chk("rst_during_count", 32'(count_out), 32'd0);
    chk("rst_during_busy", 32'(busy), 32'd0);
    chk("rst_during_done", 32'(done), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("rst_after_count", 32'(count_out), 32'd0);
    chk("rst_after_busy", 32'(busy), 32'd0);
    chk("rst_after_done", 32'(done), 32'd0);

    // A4 period, q=247.
    issue(A4_PERIOD, 8'd247);
    wait_done(n, b0);
    chk("a4_247_busy_first", 32'(b0), 32'd1);
    chk("a4_247_latency", 32'(n), 32'd9);
    chk("a4_247_value", 32'(count_out), 32'd21928);
    chk("a4_247_busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("a4_247_done_single", 32'(done), 32'd0);

    issue(A4_PERIOD, 8'd255);
    wait_done(n, b0);
    chk("a4_255_latency", 32'(n), 32'd9);
    chk("a4_255_value", 32'(count_out), 32'd22638);
    @(negedge clk);

    issue(A4_PERIOD, 8'd0);
    wait_done(n, b0);
    chk("q0_latency", 32'(n), 32'd9);
    chk("q0_value", 32'(count_out), 32'd0);
    @(negedge clk);

    issue(16'd65535, 8'd255);
    wait_done(n, b0);
    chk("max_latency", 32'(n), 32'd9);
    chk("max_value", 32'(count_out), 32'd65279);
    @(negedge clk);

    issue(16'd0, 8'd200);
    wait_done(n, b0);
    chk("div0_latency", 32'(n), 32'd9);
    chk("div0_value", 32'(count_out), 32'd0);
    @(negedge clk);

    // Start pulsed while busy must be ignored.
    issue(A4_PERIOD, 8'd247);
    @(negedge clk);
    @(negedge clk);
    divider = 16'd1;
    q_in    = 8'd10;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n, b0);
    chk("busy_start_latency", 32'(n), 32'd7);
    chk("busy_start_value", 32'(count_out), 32'd21928);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("busy_start_no_extra_done", 32'(pulses), 32'd0);
    chk("busy_start_idle", 32'(busy), 32'd0);

    // Back-to-back: start issued in the done cycle.
    issue(A4_PERIOD, 8'd255);
    wait_done(n, b0);
    chk("b2b_first_value", 32'(count_out), 32'd22638);
    issue(A4_PERIOD, 8'd128);
    wait_done(n, b0);
    chk("b2b_second_latency", 32'(n), 32'd9);
    chk("b2b_second_value", 32'(count_out), 32'd11363);
    @(negedge clk);

    // Reset in the middle of a multiplication.
    issue(A4_PERIOD, 8'd247);
    repeat (4) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    #5 nrst = 1'b0;
    #1;
    chk("abort_count_async", 32'(count_out), 32'd0);
    chk("abort_busy_async", 32'(busy), 32'd0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    nrst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);

    issue(A4_PERIOD, 8'd255);
    wait_done(n, b0);
    chk("after_abort_latency", 32'(n), 32'd9);
    chk("after_abort_value", 32'(count_out), 32'd22638);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
